// File: rtl/id_pipe_pkg.sv
// Shared decode constants for the ID stage: RV32I opcode classes, ALU op codes
// and the operand-1 source selector.
package id_pipe_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned AW_DEF      = 5;
  localparam int unsigned ALUOP_W_DEF = 4;

  typedef enum logic [6:0] {
    INST_TYPE_OP_IMM = 7'b0010011,
    INST_TYPE_OP     = 7'b0110011,
    INST_TYPE_BRANCH = 7'b1100011,
    INST_TYPE_LUI    = 7'b0110111,
    INST_TYPE_AUIPC  = 7'b0010111,
    INST_TYPE_JAL    = 7'b1101111,
    INST_TYPE_JALR   = 7'b1100111,
    INST_TYPE_LOAD   = 7'b0000011,
    INST_TYPE_STORE  = 7'b0100011
  } inst_type_e;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [2:0] F3_WORD   = 3'b010;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_ZERO = 2'd1,
    OP1_PC   = 2'd2
  } op1_sel_e;

endpackage

// File: rtl/id_decode_core.sv
// Purely combinational RV32I decode: instruction word to immediate, ALU op,
// class flags and register usage. Illegal encodings come out with everything zeroed.
module id_decode_core
  import id_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned ALUOP_W = ALUOP_W_DEF
) (
  input  logic [31:0]        inst_i,
  output logic [AW-1:0]      rs1_addr_o,
  output logic [AW-1:0]      rs2_addr_o,
  output logic [AW-1:0]      rd_addr_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               reg_wen_o,
  output op1_sel_e           op1_sel_o,
  output logic               op2_rs2_o,
  output logic               is_load_o,
  output logic               is_store_o,
  output logic               is_branch_o,
  output logic               is_jump_o,
  output logic               illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immI, immS, immB, immU, immJ;

  logic [31:0] imm32;
  logic [3:0]  alu;
  logic        use1, use2, wr, legal, ld, st, br, jp;
  op1_sel_e    sel;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  assign immI = {{20{inst_i[31]}}, inst_i[31:20]};
  assign immS = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign immB = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign immU = {inst_i[31:12], 12'b0};
  assign immJ = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    imm32 = '0;
    alu   = ALU_ADD;
    use1  = 1'b0;
    use2  = 1'b0;
    wr    = 1'b0;
    legal = 1'b1;
    ld    = 1'b0;
    st    = 1'b0;
    br    = 1'b0;
    jp    = 1'b0;
    sel   = OP1_RS1;
    case (opcode)
      INST_TYPE_OP_IMM: begin
        use1  = 1'b1;
        wr    = 1'b1;
        imm32 = immI;
        case (funct3)
          3'b000:  alu = ALU_ADD;
          3'b010:  alu = ALU_SLT;
          3'b011:  alu = ALU_SLTU;
          3'b100:  alu = ALU_XOR;
          3'b110:  alu = ALU_OR;
          3'b111:  alu = ALU_AND;
          3'b001: begin
            alu   = ALU_SLL;
            legal = (funct7 == F7_BASE);
          end
          default: begin
            // Shift-right immediates carry the arithmetic select in funct7
            if (funct7 == F7_BASE)     alu = ALU_SRL;
            else if (funct7 == F7_ALT) alu = ALU_SRA;
            else                       legal = 1'b0;
          end
        endcase
      end
      INST_TYPE_OP: begin
        use1 = 1'b1;
        use2 = 1'b1;
        wr   = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  alu = ALU_ADD;
            3'b001:  alu = ALU_SLL;
            3'b010:  alu = ALU_SLT;
            3'b011:  alu = ALU_SLTU;
            3'b100:  alu = ALU_XOR;
            3'b101:  alu = ALU_SRL;
            3'b110:  alu = ALU_OR;
            default: alu = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          alu = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      INST_TYPE_BRANCH: begin
        use1  = 1'b1;
        use2  = 1'b1;
        br    = 1'b1;
        imm32 = immB;
        // Equality compares subtract; ordered compares reuse the set-less-than ops
        case (funct3)
          3'b000, 3'b001: alu = ALU_SUB;
          3'b100, 3'b101: alu = ALU_SLT;
          3'b110, 3'b111: alu = ALU_SLTU;
          default:        legal = 1'b0;
        endcase
      end
      INST_TYPE_LUI: begin
        wr    = 1'b1;
        imm32 = immU;
        sel   = OP1_ZERO;
      end
      INST_TYPE_AUIPC: begin
        wr    = 1'b1;
        imm32 = immU;
        sel   = OP1_PC;
      end
      INST_TYPE_JAL: begin
        wr    = 1'b1;
        jp    = 1'b1;
        imm32 = immJ;
        sel   = OP1_PC;
      end
      INST_TYPE_JALR: begin
        use1  = 1'b1;
        wr    = 1'b1;
        jp    = 1'b1;
        imm32 = immI;
        legal = (funct3 == 3'b000);
      end
      INST_TYPE_LOAD: begin
        use1  = 1'b1;
        wr    = 1'b1;
        ld    = 1'b1;
        imm32 = immI;
        legal = (funct3 == F3_WORD);
      end
      INST_TYPE_STORE: begin
        use1  = 1'b1;
        use2  = 1'b1;
        st    = 1'b1;
        imm32 = immS;
        legal = (funct3 == F3_WORD);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    rs1_addr_o  = (legal && use1) ? AW'(inst_i[19:15]) : '0;
    rs2_addr_o  = (legal && use2) ? AW'(inst_i[24:20]) : '0;
    rd_addr_o   = (legal && wr)   ? AW'(inst_i[11:7])  : '0;
    reg_wen_o   = legal && wr && (inst_i[11:7] != 5'd0);
    imm_o       = legal ? XLEN'($signed(imm32)) : '0;
    alu_op_o    = legal ? ALUOP_W'(alu) : '0;
    op1_sel_o   = sel;
    op2_rs2_o   = legal && use2;
    is_load_o   = legal && ld;
    is_store_o  = legal && st;
    is_branch_o = legal && br;
    is_jump_o   = legal && jp;
    illegal_o   = !legal;
  end

endmodule

// File: rtl/id_pipe.sv
// Registered decode stage: decode, WB bypass, load-use stall, flush and a
// valid/ready output register between if_id and execute.
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned ALUOP_W = ALUOP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        inst_i,
  input  logic [XLEN-1:0]    inst_addr_i,
  output logic [AW-1:0]      rs1_addr_o,
  output logic [AW-1:0]      rs2_addr_o,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  input  logic               wb_wen_i,
  input  logic [AW-1:0]      wb_addr_i,
  input  logic [XLEN-1:0]    wb_data_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        inst_o,
  output logic [XLEN-1:0]    inst_addr_o,
  output logic [XLEN-1:0]    op1_o,
  output logic [XLEN-1:0]    op2_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic [AW-1:0]      rd_addr_o,
  output logic               reg_wen_o,
  output logic               is_load_o,
  output logic               is_store_o,
  output logic               is_branch_o,
  output logic               is_jump_o,
  output logic               illegal_o
);

  logic [AW-1:0]      decRd;
  logic [XLEN-1:0]    decImm;
  logic [ALUOP_W-1:0] decAlu;
  logic               decWen, decOp2Rs2, decLd, decSt, decBr, decJp, decIll;
  op1_sel_e           decOp1Sel;

  id_decode_core #(.XLEN(XLEN), .AW(AW), .ALUOP_W(ALUOP_W)) u_decode (
    .inst_i      (inst_i),
    .rs1_addr_o  (rs1_addr_o),
    .rs2_addr_o  (rs2_addr_o),
    .rd_addr_o   (decRd),
    .imm_o       (decImm),
    .alu_op_o    (decAlu),
    .reg_wen_o   (decWen),
    .op1_sel_o   (decOp1Sel),
    .op2_rs2_o   (decOp2Rs2),
    .is_load_o   (decLd),
    .is_store_o  (decSt),
    .is_branch_o (decBr),
    .is_jump_o   (decJp),
    .illegal_o   (decIll)
  );

  logic               valid_q, valid_d;
  logic [31:0]        inst_q, inst_d;
  logic [XLEN-1:0]    pc_q, pc_d, op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [ALUOP_W-1:0] alu_q, alu_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic               wen_q, wen_d, ld_q, ld_d, st_q, st_d;
  logic               br_q, br_d, jp_q, jp_d, ill_q, ill_d;

  logic [XLEN-1:0]    rs1Fwd, rs2Fwd, op1Dec, op2Dec;
  logic               hazard, accept;

  // A writeback to the register being read this cycle wins over the stale regfile value
  assign rs1Fwd = (wb_wen_i && wb_addr_i != '0 && wb_addr_i == rs1_addr_o) ? wb_data_i : rs1_data_i;
  assign rs2Fwd = (wb_wen_i && wb_addr_i != '0 && wb_addr_i == rs2_addr_o) ? wb_data_i : rs2_data_i;

  always_comb begin
    op1Dec = rs1Fwd;
    if (decIll)                    op1Dec = '0;
    else if (decOp1Sel == OP1_ZERO) op1Dec = '0;
    else if (decOp1Sel == OP1_PC)   op1Dec = inst_addr_i;
    op2Dec = decIll ? '0 : (decOp2Rs2 ? rs2Fwd : decImm);
  end

  // Unused source addresses are forced to zero, so matching rd (nonzero) implies a real use
  assign hazard = valid_q && ld_q && (rd_q != '0) && in_valid_i &&
                  ((rs1_addr_o == rd_q) || (rs2_addr_o == rd_q));

  assign in_ready_o = flush_i | ((!valid_q | out_ready_i) & !hazard);
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    ld_d    = ld_q;
    st_d    = st_q;
    br_d    = br_q;
    jp_d    = jp_q;
    ill_d   = ill_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      inst_d  = inst_i;
      pc_d    = inst_addr_i;
      op1_d   = op1Dec;
      op2_d   = op2Dec;
      imm_d   = decImm;
      alu_d   = decAlu;
      rd_d    = decRd;
      wen_d   = decWen;
      ld_d    = decLd;
      st_d    = decSt;
      br_d    = decBr;
      jp_d    = decJp;
      ill_d   = decIll;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      br_q    <= 1'b0;
      jp_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      br_q    <= br_d;
      jp_q    <= jp_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid_o = valid_q;
  assign inst_o      = inst_q;
  assign inst_addr_o = pc_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign imm_o       = imm_q;
  assign alu_op_o    = alu_q;
  assign rd_addr_o   = rd_q;
  assign reg_wen_o   = wen_q;
  assign is_load_o   = ld_q;
  assign is_store_o  = st_q;
  assign is_branch_o = br_q;
  assign is_jump_o   = jp_q;
  assign illegal_o   = ill_q;

endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: directed scenarios then randomized traffic, all checked
// against an instruction-level reference model of the decode stage.
module tb_id_pipe;
  import id_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o;
  logic [31:0] inst_i, inst_addr_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic        wb_wen_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        flush_i, out_valid_o, out_ready_i;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, imm_o;
  logic [3:0]  alu_op_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o, is_load_o, is_store_o, is_branch_o, is_jump_o, illegal_o;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  assign rs1_data_i = rf[rs1_addr_o];
  assign rs2_data_i = rf[rs2_addr_o];

  id_pipe #(.XLEN(32), .AW(5), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .wb_wen_i(wb_wen_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o), .alu_op_o(alu_op_o),
    .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o),
    .is_load_o(is_load_o), .is_store_o(is_store_o),
    .is_branch_o(is_branch_o), .is_jump_o(is_jump_o), .illegal_o(illegal_o)
  );

  typedef struct packed {
    logic [31:0] inst, pc, op1, op2, imm;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        wen, ld, st, br, jp, ill;
  } bund_t;

  localparam logic [3:0] F3_OP [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                       ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [6:0] OPCS [9] = '{7'h13, 7'h33, 7'h63, 7'h37, 7'h17,
                                      7'h6f, 7'h67, 7'h03, 7'h23};

  bund_t mq;
  logic  mv;
  logic  zeroChk;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] regVal(input logic [4:0] idx);
    if (wb_wen_i && wb_addr_i != 5'd0 && wb_addr_i == idx) return wb_data_i;
    return rf[idx];
  endfunction

  // Reference decode written from the ISA rules: immediates assembled arithmetically
  function automatic void refDecode(input logic [31:0] w, input logic [31:0] pc,
                                    output bund_t b, output logic [4:0] r1, output logic [4:0] r2);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] sgn, imm;
    logic        u1, u2, wr, ok;
    logic [3:0]  op;
    f3 = w[14:12];
    f7 = w[31:25];
    sgn = {32{w[31]}};
    u1 = 0; u2 = 0; wr = 0; ok = 1; imm = 0; op = ALU_ADD;
    b = '0; r1 = 0; r2 = 0;
    case (w[6:0])
      7'h13: begin
        u1 = 1; wr = 1; imm = (sgn << 11) | 32'(w[30:20]); op = F3_OP[f3];
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        if (f3 == 3'd5) begin
          ok = (f7 == 7'h00) || (f7 == 7'h20);
          if (f7 == 7'h20) op = ALU_SRA;
        end
      end
      7'h33: begin
        u1 = 1; u2 = 1; wr = 1; op = F3_OP[f3];
        if (f7 == 7'h20) begin
          if (f3 == 3'd0)      op = ALU_SUB;
          else if (f3 == 3'd5) op = ALU_SRA;
          else                 ok = 0;
        end else if (f7 != 7'h00) ok = 0;
      end
      7'h63: begin
        u1 = 1; u2 = 1; b.br = 1;
        imm = (sgn << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        ok = (f3 != 3'd2) && (f3 != 3'd3);
        op = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
      end
      7'h37, 7'h17: begin wr = 1; imm = w & 32'hFFFFF000; end
      7'h6f: begin
        wr = 1; b.jp = 1;
        imm = (sgn << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      end
      7'h67: begin u1 = 1; wr = 1; b.jp = 1; imm = (sgn << 11) | 32'(w[30:20]); ok = (f3 == 3'd0); end
      7'h03: begin u1 = 1; wr = 1; b.ld = 1; imm = (sgn << 11) | 32'(w[30:20]); ok = (f3 == 3'd2); end
      7'h23: begin
        u1 = 1; u2 = 1; b.st = 1; ok = (f3 == 3'd2);
        imm = (sgn << 11) | (32'(w[30:25]) << 5) | 32'(w[11:7]);
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      b = '0;
      b.ill = 1;
    end else begin
      r1 = u1 ? w[19:15] : 5'd0;
      r2 = u2 ? w[24:20] : 5'd0;
      b.imm = imm;
      b.alu = op;
      b.rd  = wr ? w[11:7] : 5'd0;
      b.wen = (b.rd != 5'd0);
      if (w[6:0] == 7'h37)                         b.op1 = 0;
      else if (w[6:0] == 7'h17 || w[6:0] == 7'h6f) b.op1 = pc;
      else                                         b.op1 = regVal(r1);
      b.op2 = u2 ? regVal(r2) : imm;
    end
    b.inst = w;
    b.pc   = pc;
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = OPCS[$urandom_range(0, 8)];
    if ($urandom_range(0, 1) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 1) != 0) w[14:12] = 3'd2;
    w[11:7]  = 5'($urandom_range(0, 4));
    w[19:15] = 5'($urandom_range(0, 4));
    w[24:20] = 5'($urandom_range(0, 4));
    return w;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [31:0] pc,
                               input logic ordy, input logic fl, input logic wen,
                               input logic [4:0] wa, input logic [31:0] wd);
    in_valid_i  = v;
    inst_i      = w;
    inst_addr_i = pc;
    out_ready_i = ordy;
    flush_i     = fl;
    wb_wen_i    = wen;
    wb_addr_i   = wa;
    wb_data_i   = wd;
  endtask

  task automatic checkOutput();
    chk("out_valid", out_valid_o, mv);
    if (mv || zeroChk) begin
      chk("inst", inst_o, mq.inst);
      chk("inst_addr", inst_addr_o, mq.pc);
      chk("op1", op1_o, mq.op1);
      chk("op2", op2_o, mq.op2);
      chk("imm", imm_o, mq.imm);
      chk("alu_op", alu_op_o, mq.alu);
      chk("rd_addr", rd_addr_o, mq.rd);
      chk("reg_wen", reg_wen_o, mq.wen);
      chk("is_load", is_load_o, mq.ld);
      chk("is_store", is_store_o, mq.st);
      chk("is_branch", is_branch_o, mq.br);
      chk("is_jump", is_jump_o, mq.jp);
      chk("illegal", illegal_o, mq.ill);
    end
  endtask

  // One clock: check combinational outputs, predict the register update, check after the edge
  task automatic cycle();
    bund_t d;
    logic [4:0] r1, r2;
    logic hz, rdy;
    #1;
    refDecode(inst_i, inst_addr_i, d, r1, r2);
    chk("rs1_addr", rs1_addr_o, r1);
    chk("rs2_addr", rs2_addr_o, r2);
    hz  = mv && mq.ld && (mq.rd != 5'd0) && in_valid_i && ((r1 == mq.rd) || (r2 == mq.rd));
    rdy = flush_i | ((!mv | out_ready_i) & !hz);
    chk("in_ready", in_ready_o, rdy);
    @(posedge clk);
    if (rst) begin
      mv = 0; mq = '0; zeroChk = 1;
    end else begin
      zeroChk = 0;
      if (flush_i)                 mv = 0;
      else if (in_valid_i && rdy) begin mv = 1; mq = d; end
      else if (out_ready_i)        mv = 0;
    end
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 0;
    mv = 0; mq = '0; zeroChk = 0;

    rst = 1;
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    cycle();
    cycle();
    rst = 0;

    applyStimulus(1, 32'h00500093, 32'h100, 1, 0, 0, 0, 0);
    cycle();
    chk("addi_op1", op1_o, 0);
    chk("addi_op2", op2_o, 5);
    chk("addi_rd", rd_addr_o, 1);
    chk("addi_wen", reg_wen_o, 1);
    chk("addi_alu", alu_op_o, ALU_ADD);

    rf[1] = 9; rf[2] = 4;
    applyStimulus(1, 32'h402081B3, 32'h104, 1, 0, 1, 5'd2, 32'd7);
    cycle();
    chk("sub_op1", op1_o, 9);
    chk("sub_op2_bypass", op2_o, 7);
    chk("sub_alu", alu_op_o, ALU_SUB);

    applyStimulus(1, 32'h0000A283, 32'h108, 1, 0, 0, 0, 0);
    cycle();
    applyStimulus(1, 32'h00528333, 32'h10C, 1, 0, 0, 0, 0);
    #1;
    chk("loaduse_ready", in_ready_o, 0);
    cycle();
    chk("loaduse_bubble", out_valid_o, 0);
    cycle();
    chk("loaduse_issue_valid", out_valid_o, 1);
    chk("loaduse_issue_inst", inst_o, 32'h00528333);

    applyStimulus(1, 32'h00700393, 32'h110, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_inst", inst_o, 32'h00528333);
      chk("stall_ready", in_ready_o, 0);
    end
    out_ready_i = 1;
    cycle();
    chk("release_inst", inst_o, 32'h00700393);

    applyStimulus(1, 32'h00208463, 32'h114, 1, 0, 0, 0, 0);
    cycle();
    chk("beq_branch", is_branch_o, 1);
    chk("beq_imm", imm_o, 8);
    applyStimulus(1, 32'h00528333, 32'h118, 0, 1, 0, 0, 0);
    cycle();
    chk("flush_valid", out_valid_o, 0);
    applyStimulus(0, 0, 32'h11C, 1, 0, 0, 0, 0);
    cycle();
    chk("flush_dropped", out_valid_o, 0);

    applyStimulus(1, 32'hFFFFFFFF, 32'h120, 1, 0, 0, 0, 0);
    cycle();
    chk("illegal_flag", illegal_o, 1);
    chk("illegal_wen", reg_wen_o, 0);

    applyStimulus(1, 32'h0000A283, 32'h124, 1, 0, 0, 0, 0);
    cycle();
    applyStimulus(1, 32'h00528333, 32'h128, 0, 0, 0, 0, 0);
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_stall_valid", out_valid_o, 0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(1, 4)] = $urandom;
      applyStimulus($urandom_range(0, 3) != 0, randInst(), $urandom & 32'hFFFFFFFC,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 1) != 0, 5'($urandom_range(0, 4)), $urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
